// File: rtl/divider_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters access to one shared divider,
// one request in flight at a time, with divide-by-zero bypass and a WAIT timeout.
module divider_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [NUM_REQ-1:0]         req_in,
  input  logic [NUM_REQ*WIDTH-1:0]   dividend_in,
  input  logic [NUM_REQ*WIDTH-1:0]   divisor_in,
  output logic [NUM_REQ-1:0]         grant_out,
  output logic [NUM_REQ-1:0]         result_valid_out,
  output logic [WIDTH-1:0]           quotient_out,
  output logic [WIDTH-1:0]           remainder_out,
  output logic                       error_out,
  output logic [WIDTH-1:0]           div_dividend_out,
  output logic [WIDTH-1:0]           div_divisor_out,
  output logic                       div_valid_out,
  input  logic [WIDTH-1:0]           div_quotient_in,
  input  logic [WIDTH-1:0]           div_remainder_in,
  input  logic                       div_valid_in,
  input  logic                       div_error_in,
  input  logic                       div_busy_in
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW   = $clog2(TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1'b1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t            state_r;
  logic [IDXW-1:0]   idx_r;
  logic [IDXW-1:0]   rr_ptr_r;
  logic [CW-1:0]     cnt_r;
  logic [IDXW:0]     pick_s;
  logic [IDXW-1:0]   sel_idx_s;
  logic [WIDTH-1:0]  dvd_arr_s [NUM_REQ];
  logic [WIDTH-1:0]  dvs_arr_s [NUM_REQ];

  // First set request at or above ptr, wrapping; MSB flags that one was found.
  function automatic logic [IDXW:0] pick(input logic [NUM_REQ-1:0] req,
                                         input logic [IDXW-1:0]    ptr);
    logic [IDXW:0] res;
    int            j;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j   = int'(ptr) + k;
      j   = (j >= NUM_REQ) ? j - NUM_REQ : j;
      res = req[j] ? {1'b1, IDXW'(j)} : res;
    end
    return res;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign dvd_arr_s[g] = dividend_in[g*WIDTH +: WIDTH];
    assign dvs_arr_s[g] = divisor_in[g*WIDTH +: WIDTH];
  end

  assign pick_s    = pick(req_in, rr_ptr_r);
  assign sel_idx_s = pick_s[IDXW-1:0];

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r          <= IDLE;
      idx_r            <= '0;
      rr_ptr_r         <= '0;
      cnt_r            <= '0;
      grant_out        <= '0;
      result_valid_out <= '0;
      quotient_out     <= '0;
      remainder_out    <= '0;
      error_out        <= 1'b0;
      div_dividend_out <= '0;
      div_divisor_out  <= '0;
      div_valid_out    <= 1'b0;
    end else begin
      grant_out        <= '0;
      result_valid_out <= '0;
      div_valid_out    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pick_s[IDXW]) begin
            idx_r            <= sel_idx_s;
            grant_out        <= ONE_HOT0 << sel_idx_s;
            div_dividend_out <= dvd_arr_s[sel_idx_s];
            div_divisor_out  <= dvs_arr_s[sel_idx_s];
            // A zero divisor never reaches the divider; answer immediately.
            if (dvs_arr_s[sel_idx_s] == '0) begin
              state_r          <= RESPOND;
              result_valid_out <= ONE_HOT0 << sel_idx_s;
              error_out        <= 1'b1;
              quotient_out     <= '1;
              remainder_out    <= dvd_arr_s[sel_idx_s];
            end else begin
              state_r <= ISSUE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (!div_busy_in) begin
            div_valid_out <= 1'b1;
            cnt_r         <= '0;
            state_r       <= WAIT;
          end else begin
            state_r <= ISSUE;
          end
        end
        WAIT: begin
          if (div_valid_in) begin
            state_r          <= RESPOND;
            result_valid_out <= ONE_HOT0 << idx_r;
            quotient_out     <= div_quotient_in;
            remainder_out    <= div_remainder_in;
            error_out        <= div_error_in;
          end else if (cnt_r == CW'(TIMEOUT - 1)) begin
            state_r          <= RESPOND;
            result_valid_out <= ONE_HOT0 << idx_r;
            quotient_out     <= '0;
            remainder_out    <= '0;
            error_out        <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        RESPOND: begin
          rr_ptr_r         <= (idx_r == IDXW'(NUM_REQ - 1)) ? '0 : idx_r + IDXW'(1);
          div_dividend_out <= '0;
          div_divisor_out  <= '0;
          state_r          <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter: hand-computed expectations go into queues,
// a negedge monitor pops and compares whenever grant or result pulses appear.
module tb_divider_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  typedef struct packed {
    logic [3:0]  oh;
    logic [31:0] q;
    logic [31:0] r;
    logic        err;
  } res_t;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_in;
  logic [N*W-1:0] dividend_in, divisor_in;
  logic [N-1:0]   grant_out, result_valid_out;
  logic [W-1:0]   quotient_out, remainder_out, div_dividend_out, div_divisor_out;
  logic           error_out, div_valid_out;
  logic [W-1:0]   div_quotient_in, div_remainder_in;
  logic           div_valid_in, div_error_in, div_busy_in;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int grant_count = 0, res_count = 0, dv_count = 0;
  int grant_cyc = 0, res_cyc = 0, dv_cyc = 0, req_cyc = 0;
  int div_lat = 2;
  bit div_silent = 1'b0;

  logic [3:0] exp_grant [$];
  res_t       exp_res   [$];

  divider_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(64)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .req_in(req_in),
    .dividend_in(dividend_in), .divisor_in(divisor_in),
    .grant_out(grant_out), .result_valid_out(result_valid_out),
    .quotient_out(quotient_out), .remainder_out(remainder_out), .error_out(error_out),
    .div_dividend_out(div_dividend_out), .div_divisor_out(div_divisor_out),
    .div_valid_out(div_valid_out), .div_quotient_in(div_quotient_in),
    .div_remainder_in(div_remainder_in), .div_valid_in(div_valid_in),
    .div_error_in(div_error_in), .div_busy_in(div_busy_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_res(input logic [3:0] oh, input logic [31:0] q,
                          input logic [31:0] r, input logic err);
    res_t e;
    e.oh = oh; e.q = q; e.r = r; e.err = err;
    exp_res.push_back(e);
  endtask

  // Monitor: scoreboard compare on every grant or result pulse.
  always @(negedge clk) begin
    if (div_valid_out) begin
      dv_count <= dv_count + 1;
      dv_cyc   <= cyc;
    end
    if (grant_out != 4'b0000) begin
      grant_count <= grant_count + 1;
      grant_cyc   <= cyc;
      if (exp_grant.size() == 0) check("unexpected_grant", {60'd0, grant_out}, 64'd0);
      else check("grant", {60'd0, grant_out}, {60'd0, exp_grant.pop_front()});
    end
    if (result_valid_out != 4'b0000) begin
      res_count <= res_count + 1;
      res_cyc   <= cyc;
      if (exp_res.size() == 0) begin
        check("unexpected_result", {60'd0, result_valid_out}, 64'd0);
      end else begin
        res_t e;
        e = exp_res.pop_front();
        check("result_valid", {60'd0, result_valid_out}, {60'd0, e.oh});
        check("quotient", {32'd0, quotient_out}, {32'd0, e.q});
        check("remainder", {32'd0, remainder_out}, {32'd0, e.r});
        check("error", {63'd0, error_out}, {63'd0, e.err});
      end
    end
  end

  // Divider model: answers div_lat cycles after each start strobe unless silenced.
  initial begin
    logic [31:0] dvd, dvs;
    div_valid_in = 1'b0; div_quotient_in = '0; div_remainder_in = '0; div_error_in = 1'b0;
    forever begin
      @(negedge clk);
      if (div_valid_out && !div_silent) begin
        repeat (div_lat) @(posedge clk);
        #1;
        dvd = div_dividend_out;
        dvs = div_divisor_out;
        div_quotient_in  = (dvs == 32'd0) ? 32'hFFFF_FFFF : dvd / dvs;
        div_remainder_in = (dvs == 32'd0) ? dvd : dvd % dvs;
        div_valid_in = 1'b1;
        @(posedge clk);
        #1;
        div_valid_in = 1'b0;
      end
    end
  end

  function automatic int cur(input int sel);
    return (sel == 0) ? grant_count : (sel == 1) ? res_count : dv_count;
  endfunction

  task automatic wait_for(input string name, input int sel, input int target);
    int k;
    k = 0;
    while (cur(sel) < target && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, 64'(cur(sel)), 64'(target));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int idx, input logic [31:0] dvd, input logic [31:0] dvs);
    dividend_in[idx*32 +: 32] = dvd;
    divisor_in[idx*32 +: 32]  = dvs;
    req_in[idx] = 1'b1;
    req_cyc = cyc;
    @(posedge clk); #1;
    req_in[idx] = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_grant"}, {60'd0, grant_out}, 64'd0);
    check({tag, "_rvalid"}, {60'd0, result_valid_out}, 64'd0);
    check({tag, "_quot"}, {32'd0, quotient_out}, 64'd0);
    check({tag, "_rem"}, {32'd0, remainder_out}, 64'd0);
    check({tag, "_err"}, {63'd0, error_out}, 64'd0);
    check({tag, "_dvalid"}, {63'd0, div_valid_out}, 64'd0);
    check({tag, "_ddvd"}, {32'd0, div_dividend_out}, 64'd0);
    check({tag, "_ddvs"}, {32'd0, div_divisor_out}, 64'd0);
  endtask

  initial begin
    int dv0, r0;
    rst_n = 1'b0; req_in = '0; dividend_in = '0; divisor_in = '0; div_busy_in = 1'b0;
    step(3);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    step(1);

    // Round robin from pointer 0 with all four requesting.
    dividend_in = {32'd9, 32'd50, 32'd81, 32'd100};
    divisor_in  = {32'd10, 32'd4, 32'd9, 32'd7};
    exp_grant.push_back(4'b0001); exp_grant.push_back(4'b0010);
    exp_grant.push_back(4'b0100); exp_grant.push_back(4'b1000);
    exp_grant.push_back(4'b0001);
    push_res(4'b0001, 32'd14, 32'd2, 1'b0);
    push_res(4'b0010, 32'd9, 32'd0, 1'b0);
    push_res(4'b0100, 32'd12, 32'd2, 1'b0);
    push_res(4'b1000, 32'd0, 32'd9, 1'b0);
    push_res(4'b0001, 32'd14, 32'd2, 1'b0);
    req_in = 4'b1111;
    wait_for("rr_grants", 0, grant_count + 5);
    req_in = 4'b0000;
    wait_for("rr_results", 1, 5);

    // Single request, divider answers 10 cycles later; minimum latencies.
    dividend_in = '0; divisor_in = '0; div_lat = 10;
    exp_grant.push_back(4'b0001);
    push_res(4'b0001, 32'd14, 32'd2, 1'b0);
    dv0 = dv_count;
    issue(0, 32'd100, 32'd7);
    wait_for("basic_result", 1, res_count + 1);
    check("grant_latency", 64'(grant_cyc - req_cyc), 64'd1);
    check("start_latency", 64'(dv_cyc - req_cyc), 64'd2);
    check("respond_latency", 64'(res_cyc - dv_cyc), 64'd11);
    check("basic_dv_pulses", 64'(dv_count - dv0), 64'd1);
    step(3);
    check("quot_hold", {32'd0, quotient_out}, 64'd14);
    check("rem_hold", {32'd0, remainder_out}, 64'd2);

    // Divide by zero never reaches the divider.
    exp_grant.push_back(4'b0100);
    push_res(4'b0100, 32'hFFFF_FFFF, 32'd55, 1'b1);
    dv0 = dv_count;
    issue(2, 32'd55, 32'd0);
    wait_for("dbz_result", 1, res_count + 1);
    step(3);
    check("dbz_no_start", 64'(dv_count - dv0), 64'd0);

    // Divider busy for 5 cycles at ISSUE.
    div_lat = 1;
    exp_grant.push_back(4'b1000);
    push_res(4'b1000, 32'd333, 32'd1, 1'b0);
    dv0 = dv_count;
    issue(3, 32'd1000, 32'd3);
    div_busy_in = 1'b1;
    step(5);
    div_busy_in = 1'b0;
    wait_for("busy_result", 1, res_count + 1);
    check("busy_start_latency", 64'(dv_cyc - req_cyc), 64'd7);
    check("busy_dv_pulses", 64'(dv_count - dv0), 64'd1);

    // Divider never answers: timeout after 64 WAIT cycles.
    div_silent = 1'b1;
    exp_grant.push_back(4'b0010);
    push_res(4'b0010, 32'd0, 32'd0, 1'b1);
    issue(1, 32'd77, 32'd5);
    wait_for("timeout_result", 1, res_count + 1);
    check("timeout_latency", 64'(res_cyc - dv_cyc), 64'd64);
    div_silent = 1'b0;
    step(2);

    // Reset during WAIT; the divider's late answer must be ignored.
    div_lat = 20;
    exp_grant.push_back(4'b0100);
    dv0 = dv_count;
    issue(2, 32'd9, 32'd3);
    wait_for("rst_start", 2, dv0 + 1);
    step(3);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    step(1);
    rst_n = 1'b1;
    r0 = res_count;
    step(30);
    check("rst_no_result", 64'(res_count - r0), 64'd0);
    check("rst_quot_zero", {32'd0, quotient_out}, 64'd0);
    check("rst_err_zero", {63'd0, error_out}, 64'd0);

    div_lat = 3;
    exp_grant.push_back(4'b0010);
    push_res(4'b0010, 32'd7, 32'd3, 1'b0);
    issue(1, 32'd45, 32'd6);
    wait_for("post_rst_result", 1, r0 + 1);
    step(2);

    check("grant_queue_empty", 64'(exp_grant.size()), 64'd0);
    check("result_queue_empty", 64'(exp_res.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/divider_arbiter.md
DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001: Parameter NUM_REQ, default 4; number of requesters sharing one divider.
REQ-002: Parameter WIDTH, default 32; operand and result width.
REQ-003: Parameter TIMEOUT, default 64; maximum cycles spent in WAIT before forced error.
REQ-004: clk_in  input  1  sole clock; all logic on rising edge.
REQ-005: rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006: req_in  input  NUM_REQ  per-requester division request, level.
REQ-007: dividend_in  input  NUM_REQ*WIDTH  packed dividends; slice i belongs to requester i.
REQ-008: divisor_in  input  NUM_REQ*WIDTH  packed divisors; slice i belongs to requester i.
REQ-009: grant_out  output  NUM_REQ  one-hot, one-cycle pulse: operands of requester i captured.
REQ-010: result_valid_out  output  NUM_REQ  one-hot, one-cycle pulse: result for requester i on shared result bus.
REQ-011: quotient_out  output  WIDTH  shared quotient bus.
REQ-012: remainder_out  output  WIDTH  shared remainder bus.
REQ-013: error_out  output  1  qualifies result_valid_out; divide-by-zero, divider error or timeout.
REQ-014: div_dividend_out / div_divisor_out  output  WIDTH each  operands to divider.
REQ-015: div_valid_out  output  1  one-cycle start strobe to divider.
REQ-016: div_quotient_in / div_remainder_in  input  WIDTH each  divider results.
REQ-017: div_valid_in, div_error_in, div_busy_in  input  1 each  divider status.

Function
REQ-018: States IDLE, ISSUE, WAIT, RESPOND; exactly one request in flight.
REQ-019: IDLE: at an edge with req_in nonzero, select first set bit searching upward from rr_ptr (wrapping); latch index and operands; next cycle grant_out[index]=1.
REQ-020: IDLE transition: divisor zero -> RESPOND with error_out=1, quotient_out=all ones, remainder_out=dividend; otherwise -> ISSUE.
REQ-021: ISSUE: div_valid_out=1 for exactly one cycle when div_busy_in=0, then -> WAIT; while div_busy_in=1 hold ISSUE with div_valid_out=0.
REQ-022: div_dividend_out/div_divisor_out hold latched operands from grant until return to IDLE.
REQ-023: WAIT: on div_valid_in=1 capture quotient, remainder, div_error_in -> RESPOND.
REQ-024: WAIT: cycle counter starts at 0 on entry; reaching TIMEOUT-1 without div_valid_in -> RESPOND, error_out=1, quotient/remainder 0.
REQ-025: RESPOND: result_valid_out[index]=1 one cycle with results; rr_ptr <= (index+1) mod NUM_REQ; -> IDLE.
REQ-026: quotient_out, remainder_out, error_out hold last response until next RESPOND.
REQ-027: req_in ignored outside IDLE; requester deasserts req_in after its grant; a request still high in IDLE is a new request.
REQ-028: div_valid_in outside WAIT ignored.
REQ-029: Minimum request-to-result latency: grant at T+1, div_valid_out at T+2, RESPOND one cycle after div_valid_in.
REQ-030: Round-robin: continuously requesting requester served at least once every NUM_REQ responses.

Reset
REQ-031: rst_n_in low asynchronously forces IDLE, rr_ptr=0, counter=0, all outputs 0.
REQ-032: Reset mid-transaction discards the in-flight request with no result_valid_out; divider result arriving after reset release ignored.

Verification
REQ-033: req_in=4'b0001, dividend 100, divisor 7, divider replies 10 cycles later -> grant_out[0], div_valid_out once, result_valid_out[0], quotient 14, remainder 2, error 0.
REQ-034: req_in=4'b1111 held, rr_ptr=0 -> grants 0,1,2,3,0 in order.
REQ-035: requester 2, divisor 0, dividend 55 -> no div_valid_out, result_valid_out[2], error 1, quotient 0xFFFFFFFF, remainder 55.
REQ-036: divider never replies -> result_valid_out after 64 WAIT cycles, error 1, quotient 0.
REQ-037: div_busy_in high 5 cycles at ISSUE -> div_valid_out only after busy drops, exactly one pulse.
REQ-038: rst_n_in low during WAIT, late div_valid_in -> no result_valid_out, outputs 0, next request served normally.
